door_controller: RTL and testbench



---
 rtl/door_controller.sv | 155 +++++++++++++++
 tb/tb_door_controller.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/door_controller.sv
// door_controller: elevator car door sequencer.
// Four-state door FSM (CLOSED, OPENING, OPEN, CLOSING) with a travel
// position counter and a dwell timer. Every output decodes from registered
// state, so no input reaches an output combinationally.
// Optional build macro DOOR_NUDGE_EN: a persistent obstruction in OPEN
// forces a close (NUDGE) once NUDGE_CYCLES consecutive cycles have elapsed.
module door_controller #(
  parameter int MOVE_CYCLES  = 16,
  parameter int DWELL_CYCLES = 64,
  parameter int NUDGE_CYCLES = 255,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       OPEN_REQ,
  input  logic       CLOSE_REQ,
  input  logic       OBSTRUCT,
  input  logic       WEIGHT_STATUS,
  output logic       MOTOR_OPEN,
  output logic       MOTOR_CLOSE,
  output logic       DOOR_STATUS,
  output logic       DOOR_CLOSED,
  output logic [1:0] DOOR_STATE,
  output logic       NUDGE
);

  typedef enum logic [1:0] {
    ST_CLOSED  = 2'b00,
    ST_OPENING = 2'b01,
    ST_OPEN    = 2'b10,
    ST_CLOSING = 2'b11
  } state_e;

  // Last OPENING position before the door counts as fully open.
  localparam logic [CNT_W-1:0] MOVE_LAST  = CNT_W'(MOVE_CYCLES - 1);
  // Dwell load value; OPEN lasts DWELL_CYCLES cycles counting down to zero.
  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] pos_q, pos_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic             nudge_q, nudge_d;
  logic             hold;
  logic             reverse;
  logic             nudge_fire;

  // Anything that keeps the door open (or sends a closing door back open).
  assign hold = OPEN_REQ | OBSTRUCT | WEIGHT_STATUS;

  // While a nudge close is in progress the light curtain no longer reverses.
  assign reverse = OPEN_REQ | WEIGHT_STATUS | (OBSTRUCT & ~nudge_q);

`ifdef DOOR_NUDGE_EN
  localparam logic [CNT_W-1:0] NUDGE_LAST = CNT_W'(NUDGE_CYCLES - 1);

  logic [CNT_W-1:0] nudge_cnt_q, nudge_cnt_d;

  // The count already covers NUDGE_CYCLES-1 blocked cycles; this is the last.
  assign nudge_fire = (state_q == ST_OPEN) && OBSTRUCT && !WEIGHT_STATUS &&
                      (nudge_cnt_q == NUDGE_LAST);

  // Consecutive blocked OPEN cycles; saturates so it never wraps.
  always_comb begin
    nudge_cnt_d = '0;
    if (state_q == ST_OPEN && OBSTRUCT && !nudge_fire) begin
      nudge_cnt_d = (nudge_cnt_q == NUDGE_LAST) ? nudge_cnt_q : nudge_cnt_q + CNT_ONE;
    end
  end

  // Nudge counter register.
  always_ff @(posedge clk) begin
    if (rst) nudge_cnt_q <= '0;
    else     nudge_cnt_q <= nudge_cnt_d;
  end
`else
  assign nudge_fire = 1'b0;
`endif

  // Next-state and counter updates for the door FSM.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    pos_d   = pos_q;
    dwell_d = dwell_q;
    nudge_d = 1'b0;

    unique case (state_q)
      ST_CLOSED: begin
        if (OPEN_REQ) state_d = ST_OPENING;
      end

      ST_OPENING: begin
        pos_d = pos_q + CNT_ONE;
        if (pos_q == MOVE_LAST) begin
          state_d = ST_OPEN;
          dwell_d = DWELL_LOAD;
        end
      end

      ST_OPEN: begin
        if (nudge_fire) begin
          state_d = ST_CLOSING;
          nudge_d = 1'b1;
        end else if (hold) begin
          dwell_d = DWELL_LOAD;
        end else if (dwell_q == '0 || CLOSE_REQ) begin
          state_d = ST_CLOSING;
        end else begin
          dwell_d = dwell_q - CNT_ONE;
        end
      end

      ST_CLOSING: begin
        if (reverse) begin
          // Reopen from the current position; travel back mirrors the
          // closing cycles already spent.
          state_d = ST_OPENING;
        end else begin
          pos_d = pos_q - CNT_ONE;
          if (pos_q == CNT_ONE) state_d = ST_CLOSED;
          else                  nudge_d = nudge_q;
        end
      end

      default: state_d = ST_CLOSED;
    endcase
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (rst) begin
      state_q <= ST_CLOSED;
      pos_q   <= '0;
      dwell_q <= '0;
      nudge_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      dwell_q <= dwell_d;
      nudge_q <= nudge_d;
    end
  end

  assign DOOR_STATE  = state_q;
  assign MOTOR_OPEN  = (state_q == ST_OPENING);
  assign MOTOR_CLOSE = (state_q == ST_CLOSING);
  assign DOOR_STATUS = (state_q != ST_CLOSED);
  assign DOOR_CLOSED = (state_q == ST_CLOSED);
  assign NUDGE       = nudge_q;

endmodule

// File: tb/tb_door_controller.sv
// tb_door_controller: directed bench for door_controller with default
// parameters (MOVE=16, DWELL=64, NUDGE=255). Build with DOOR_NUDGE_EN
// defined to check the forced-close behaviour instead of the indefinite hold.
module tb_door_controller;

  localparam logic [1:0] S_CLOSED  = 2'b00;
  localparam logic [1:0] S_OPENING = 2'b01;
  localparam logic [1:0] S_OPEN    = 2'b10;
  localparam logic [1:0] S_CLOSING = 2'b11;

  logic       clk = 1'b0;
  logic       rst;
  logic       open_req, close_req, obstruct, weight;
  logic       motor_open, motor_close, door_status, door_closed, nudge;
  logic [1:0] door_state;

  int n_cmp = 0;
  int n_err = 0;

  door_controller dut (
    .clk          (clk),
    .rst          (rst),
    .OPEN_REQ     (open_req),
    .CLOSE_REQ    (close_req),
    .OBSTRUCT     (obstruct),
    .WEIGHT_STATUS(weight),
    .MOTOR_OPEN   (motor_open),
    .MOTOR_CLOSE  (motor_close),
    .DOOR_STATUS  (door_status),
    .DOOR_CLOSED  (door_closed),
    .DOOR_STATE   (door_state),
    .NUDGE        (nudge)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       open_req;
    logic       close_req;
    logic       obstruct;
    logic       weight;
    logic [1:0] exp_state;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every output against the decode of the expected door state.
  task automatic check_all(input string name, input logic [1:0] es, input logic en);
    check({name, ".state"},       {6'd0, door_state}, {6'd0, es});
    check({name, ".motor_open"},  {7'd0, motor_open},  {7'd0, es == S_OPENING});
    check({name, ".motor_close"}, {7'd0, motor_close}, {7'd0, es == S_CLOSING});
    check({name, ".door_status"}, {7'd0, door_status}, {7'd0, es != S_CLOSED});
    check({name, ".door_closed"}, {7'd0, door_closed}, {7'd0, es == S_CLOSED});
    check({name, ".nudge"},       {7'd0, nudge},       {7'd0, en});
  endtask

  task automatic set_in(input logic r, input logic o, input logic c, input logic ob, input logic w);
    rst = r; open_req = o; close_req = c; obstruct = ob; weight = w;
  endtask

  // Advance n rising edges, leaving time 1 unit past the last edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle open request from CLOSED; door is OPENING after this.
  task automatic open_pulse(input string name);
    set_in(0, 1, 0, 0, 0);
    step(1);
    set_in(0, 0, 0, 0, 0);
    check_all({name, ".opening"}, S_OPENING, 1'b0);
  endtask

  logic [1:0] es;
  logic       en;

  initial begin
    set_in(1, 0, 0, 0, 0);
    step(2);

    // Short per-cycle vectors: reset, ignored requests, mid-travel reset.
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_CLOSED};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, S_CLOSED};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, S_CLOSED};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, S_OPENING};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, S_OPENING};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, S_OPENING};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_OPENING};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_CLOSED};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_CLOSED};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, S_OPENING};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, S_CLOSED};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_CLOSED};

    for (int i = 0; i < 12; i++) begin
      set_in(vecs[i].rst, vecs[i].open_req, vecs[i].close_req, vecs[i].obstruct, vecs[i].weight);
      step(1);
      check_all($sformatf("vec%0d", i), vecs[i].exp_state, 1'b0);
    end
    set_in(0, 0, 0, 0, 0);

    // Full cycle: 16 opening, 64 open, 16 closing, closed at edge 96.
    open_pulse("t1");
    for (int c = 1; c <= 96; c++) begin
      step(1);
      if (c < 16)      es = S_OPENING;
      else if (c < 80) es = S_OPEN;
      else if (c < 96) es = S_CLOSING;
      else             es = S_CLOSED;
      check_all($sformatf("t1.c%0d", c), es, 1'b0);
    end

    // Overload holds the door open; dwell restarts when it clears.
    open_pulse("t2");
    step(16);
    check_all("t2.open", S_OPEN, 1'b0);
    set_in(0, 0, 0, 0, 1);
    for (int i = 0; i < 200; i++) begin
      step(1);
      check({"t2.hold"}, {6'd0, door_state}, {6'd0, S_OPEN});
    end
    set_in(0, 0, 0, 0, 0);
    step(63);
    check_all("t2.dwell_end", S_OPEN, 1'b0);
    step(1);
    check_all("t2.closing", S_CLOSING, 1'b0);
    step(15);
    check_all("t2.pos1", S_CLOSING, 1'b0);
    step(1);
    check_all("t2.closed", S_CLOSED, 1'b0);

    // Obstruction reversal at pos=6, then at pos=1 on the final cycle.
    open_pulse("t3");
    step(16 + 64);
    check_all("t3.closing", S_CLOSING, 1'b0);
    step(10);
    check_all("t3.pos6", S_CLOSING, 1'b0);
    set_in(0, 0, 0, 1, 0);
    step(1);
    set_in(0, 0, 0, 0, 0);
    check_all("t3.rev6", S_OPENING, 1'b0);
    step(9);
    check_all("t3.reopen9", S_OPENING, 1'b0);
    step(1);
    check_all("t3.reopen10", S_OPEN, 1'b0);
    step(64);
    check_all("t3.closing2", S_CLOSING, 1'b0);
    step(15);
    check_all("t3.pos1", S_CLOSING, 1'b0);
    set_in(0, 0, 0, 1, 0);
    step(1);
    set_in(0, 0, 0, 0, 0);
    check_all("t3.rev1", S_OPENING, 1'b0);
    step(14);
    check_all("t3.reopen14", S_OPENING, 1'b0);
    step(1);
    check_all("t3.reopen15", S_OPEN, 1'b0);
    step(64 + 16);
    check_all("t3.closed", S_CLOSED, 1'b0);

    // Close button on dwell cycle 5; close button overridden by obstruction.
    open_pulse("t4");
    step(16 + 4);
    check_all("t4.dwell5", S_OPEN, 1'b0);
    set_in(0, 0, 1, 0, 0);
    step(1);
    set_in(0, 0, 0, 0, 0);
    check_all("t4.close_req", S_CLOSING, 1'b0);
    step(16);
    check_all("t4.closed", S_CLOSED, 1'b0);
    open_pulse("t4b");
    step(16 + 4);
    set_in(0, 0, 1, 1, 0);
    step(1);
    set_in(0, 0, 0, 0, 0);
    check_all("t4b.ignored", S_OPEN, 1'b0);
    step(63);
    check_all("t4b.reloaded", S_OPEN, 1'b0);
    step(1);
    check_all("t4b.closing", S_CLOSING, 1'b0);
    // Open request after 3 closing cycles: 3 cycles back to fully open.
    step(3);
    set_in(0, 1, 0, 0, 0);
    step(1);
    set_in(0, 0, 0, 0, 0);
    check_all("t4b.rev13", S_OPENING, 1'b0);
    step(2);
    check_all("t4b.reopen2", S_OPENING, 1'b0);
    step(1);
    check_all("t4b.reopen3", S_OPEN, 1'b0);
    step(64 + 16);
    check_all("t4b.closed", S_CLOSED, 1'b0);

    // Reset on OPENING cycle 7; position must restart from zero.
    open_pulse("t5");
    step(6);
    check_all("t5.opening7", S_OPENING, 1'b0);
    set_in(1, 0, 0, 0, 0);
    step(1);
    set_in(0, 0, 0, 0, 0);
    check_all("t5.reset", S_CLOSED, 1'b0);
    open_pulse("t5b");
    step(15);
    check_all("t5b.opening", S_OPENING, 1'b0);
    step(1);
    check_all("t5b.open", S_OPEN, 1'b0);
    step(64 + 16);
    check_all("t5b.closed", S_CLOSED, 1'b0);

    // Obstruction held 300 cycles in OPEN.
    open_pulse("t6");
    step(16);
    set_in(0, 0, 0, 1, 0);
    for (int i = 1; i <= 300; i++) begin
      step(1);
`ifdef DOOR_NUDGE_EN
      if (i < 255)      begin es = S_OPEN;    en = 1'b0; end
      else if (i < 271) begin es = S_CLOSING; en = 1'b1; end
      else              begin es = S_CLOSED;  en = 1'b0; end
`else
      es = S_OPEN;
      en = 1'b0;
`endif
      check_all($sformatf("t6.c%0d", i), es, en);
    end
    set_in(0, 0, 0, 0, 0);
`ifdef DOOR_NUDGE_EN
    step(1);
    check_all("t6.after", S_CLOSED, 1'b0);
`else
    step(63);
    check_all("t6.dwell_end", S_OPEN, 1'b0);
    step(1);
    check_all("t6.closing", S_CLOSING, 1'b0);
    step(16);
    check_all("t6.closed", S_CLOSED, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
